sram_bus_arbiter: RTL

- Shares one SRAM-like bus port between the CPU instruction channel (read-only) and the data channel (read/write).
- Sits between the mips_cpu inst_*/data_* ports and the downstream cache/AXI bridge.
- Grants address phases by priority, with an anti-starvation counter for inst.
- Tracks outstanding transactions in an in-order owner FIFO, so each bus_data_ok and its bus_rdata return to the master that issued the request.

---
 rtl/sram_bus_arbiter_pkg.sv | 6 +
 rtl/sram_bus_arbiter_owner_fifo.sv | 43 ++++
 rtl/sram_bus_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// sram_bus_arbiter_pkg: owner encodings and fixed bus size shared by the arbiter files
package sram_bus_arbiter_pkg;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// sram_bus_arbiter_owner_fifo: 1-bit in-order FIFO recording which master owns each outstanding transaction
module sram_bus_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     din_i,
  output logic                     dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & !full_o;
  assign do_pop = pop_i & !empty_o;
  assign wr_d = wr_q + AW'(do_push);
  assign rd_d = rd_q + AW'(do_pop);
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the inst and data channels, routing responses in issue order
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inst_req,
  input  logic [31:0]                    inst_addr,
  output logic                           inst_addr_ok,
  output logic                           inst_data_ok,
  output logic [31:0]                    inst_rdata,
  input  logic                           data_req,
  input  logic                           data_wr,
  input  logic [3:0]                     data_wstrb,
  input  logic [31:0]                    data_addr,
  input  logic [2:0]                     data_size,
  input  logic [31:0]                    data_wdata,
  output logic                           data_addr_ok,
  output logic                           data_data_ok,
  output logic [31:0]                    data_rdata,
  output logic                           bus_req,
  output logic                           bus_wr,
  output logic [3:0]                     bus_wstrb,
  output logic [31:0]                    bus_addr,
  output logic [2:0]                     bus_size,
  output logic [31:0]                    bus_wdata,
  input  logic                           bus_addr_ok,
  input  logic                           bus_data_ok,
  input  logic [31:0]                    bus_rdata,
  output logic [$clog2(OUTSTANDING):0]   outstanding,
  output logic                           err_unexpected_ok
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic err_q, err_d;
  logic full, empty, head, sel_inst, sel_data, fire, pop;
  assign sel_inst = inst_req & (!data_req | starve_q == SW'(STARVE_LIMIT));
  assign sel_data = data_req & !sel_inst;
  assign bus_req = (sel_inst | sel_data) & !full & !reset;
  assign fire = bus_req & bus_addr_ok;
  assign inst_addr_ok = fire & sel_inst;
  assign data_addr_ok = fire & sel_data;
  assign bus_wr = sel_data & data_wr;
  assign bus_wstrb = sel_data ? data_wstrb : '0;
  assign bus_addr = sel_inst ? inst_addr : sel_data ? data_addr : '0;
  assign bus_size = sel_inst ? SIZE_WORD : sel_data ? data_size : '0;
  assign bus_wdata = sel_data ? data_wdata : '0;
  // A response with nothing outstanding is dropped and only flagged
  assign pop = bus_data_ok & !empty & !reset;
  assign inst_data_ok = pop & (head == OWNER_INST);
  assign data_data_ok = pop & (head == OWNER_DATA);
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign err_unexpected_ok = err_q;
  always_comb begin
    starve_d = (!inst_req | inst_addr_ok) ? '0 :
               (data_addr_ok && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    err_d = err_q | (bus_data_ok & empty);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q <= err_d;
    end
  end
  sram_bus_arbiter_owner_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fire),
    .pop_i   (pop),
    .din_i   (sel_data ? OWNER_DATA : OWNER_INST),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );
endmodule
